// File: rtl/seg7_scan_counter.sv
// Multi-digit hex/BCD up/down counter with a time-multiplexed 7-segment scan output.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10000000,
    parameter int SCAN_DIV = 1000,
    parameter int HEX_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel
);
    localparam int         CW   = 4 * DIGITS;
    localparam int         PW   = $clog2(TICK_DIV);
    localparam int         SW   = $clog2(SCAN_DIV);
    localparam int         IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] MAXD = (HEX_MODE != 0) ? 4'hF : 4'h9;

    logic [PW-1:0] presc;
    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] scan_idx;
    logic          tick, scan_step;
    logic [CW-1:0] cnt_nxt, ld_val;
    logic          cnt_wrap;
    logic [3:0]    cur_dig;
    logic [6:0]    seg_nxt;
    logic [DIGITS-1:0] sel_nxt;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'h0: seg_enc = 7'h3F;  4'h1: seg_enc = 7'h06;
            4'h2: seg_enc = 7'h5B;  4'h3: seg_enc = 7'h4F;
            4'h4: seg_enc = 7'h66;  4'h5: seg_enc = 7'h6D;
            4'h6: seg_enc = 7'h7D;  4'h7: seg_enc = 7'h07;
            4'h8: seg_enc = 7'h7F;  4'h9: seg_enc = 7'h6F;
            4'hA: seg_enc = 7'h77;  4'hB: seg_enc = 7'h7C;
            4'hC: seg_enc = 7'h39;  4'hD: seg_enc = 7'h5E;
            4'hE: seg_enc = 7'h79;  default: seg_enc = 7'h71;
        endcase
    endfunction

    assign tick      = en && (presc == PW'(TICK_DIV - 1));
    assign scan_step = (scan_cnt == SW'(SCAN_DIV - 1));

    // Ripple carry/borrow: a digit only moves while every lower digit wrapped.
    always_comb begin
        cnt_nxt  = count;
        cnt_wrap = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_wrap) begin
                if (up_dn) begin
                    if (count[4*i +: 4] == MAXD) cnt_nxt[4*i +: 4] = 4'h0;
                    else begin
                        cnt_nxt[4*i +: 4] = count[4*i +: 4] + 4'h1;
                        cnt_wrap = 1'b0;
                    end
                end else begin
                    if (count[4*i +: 4] == 4'h0) cnt_nxt[4*i +: 4] = MAXD;
                    else begin
                        cnt_nxt[4*i +: 4] = count[4*i +: 4] - 4'h1;
                        cnt_wrap = 1'b0;
                    end
                end
            end
        end
    end

    // Out-of-range BCD digits load as 0 so the count never leaves 0..9.
    always_comb begin
        ld_val = load_val;
        for (int i = 0; i < DIGITS; i++)
            if (HEX_MODE == 0 && load_val[4*i +: 4] > 4'h9) ld_val[4*i +: 4] = 4'h0;
    end

    always_comb begin
        cur_dig = 4'h0;
        sel_nxt = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_dig    = count[4*i +: 4];
                sel_nxt[i] = 1'b1;
            end
        end
        seg_nxt = seg_enc(cur_dig);
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic blank;
            blank = (scan_idx != '0);
            for (int i = 0; i < DIGITS; i++)
                if (IW'(i) >= scan_idx && count[4*i +: 4] != 4'h0) blank = 1'b0;
            if (blank) seg_nxt = 7'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            wrap      <= 1'b0;
            presc     <= '0;
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= DIGITS'(1);
            segments  <= 7'h3F;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= ld_val;
                presc <= '0;
            end else if (en) begin
                if (tick) begin
                    presc <= '0;
                    count <= cnt_nxt;
                    wrap  <= cnt_wrap;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
            if (scan_step) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            digit_sel <= sel_nxt;
            segments  <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_seg7_scan_counter.sv
// Bench for seg7_scan_counter: a 2-digit hex instance checked against a value-level
// model, and a 4-digit BCD instance checked with directed constants.
module tb_seg7_scan_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_en, a_up, a_load, a_wrap;
    logic [7:0] a_lv, a_count;
    logic [6:0] a_seg;
    logic [1:0] a_sel;

    logic        b_rst_n, b_en, b_up, b_load, b_wrap;
    logic [15:0] b_lv, b_count;
    logic [6:0]  b_seg;
    logic [3:0]  b_sel;

    seg7_scan_counter #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .HEX_MODE(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lv), .count(a_count), .wrap(a_wrap), .segments(a_seg), .digit_sel(a_sel));

    seg7_scan_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .HEX_MODE(0)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lv), .count(b_count), .wrap(b_wrap), .segments(b_seg), .digit_sel(b_sel));

    int checks = 0;
    int errors = 0;

    logic [6:0] enc_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model of instance A: count kept as an integer value modulo 256.
    int         m_n, m_presc, m_scnt, m_idx;
    bit         m_wrap;
    logic [1:0] m_sel;
    logic [6:0] m_seg, m_seg2;

    function automatic logic [6:0] m_disp(input int n, input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k != 0 && (n >> (4 * k)) == 0) return 7'h00;
`endif
        return enc_tab[(n >> (4 * k)) & 15];
    endfunction

    // Advance the A model with the inputs presented for this edge, then clock once.
    task automatic cyc();
        if (!a_rst_n) begin
            m_n = 0; m_presc = 0; m_scnt = 0; m_idx = 0; m_wrap = 0;
            m_sel = 2'b01; m_seg = 7'h3F; m_seg2 = 7'h3F;
        end else begin
            m_sel  = 2'(1 << m_idx);
            m_seg  = m_disp(m_n, m_idx);
            m_wrap = 0;
            if (a_load) begin
                m_n = a_lv; m_presc = 0;
            end else if (a_en) begin
                if (m_presc == 3) begin
                    m_presc = 0;
                    if (a_up) begin m_wrap = (m_n == 255); m_n = (m_n + 1) % 256; end
                    else      begin m_wrap = (m_n == 0);   m_n = (m_n + 255) % 256; end
                end else m_presc++;
            end
            m_seg2 = m_disp(m_n, m_idx);
            if (m_scnt == 1) begin m_scnt = 0; m_idx = (m_idx + 1) % 2; end
            else m_scnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        a_rst_n = 0; b_rst_n = 0; a_load = 1; a_lv = 8'h77; b_load = 1; b_lv = 16'h4321;
        cyc(); cyc();
        a_load = 0; b_load = 0;
        checks++; if (a_count !== 8'h00) begin errors++; $display("FAIL reset_a_count got %h exp 00", a_count); end
        checks++; if (a_sel !== 2'b01 || a_seg !== 7'h3F || a_wrap !== 1'b0) begin errors++;
            $display("FAIL reset_a_disp got sel %b seg %h wrap %b exp 01 3f 0", a_sel, a_seg, a_wrap); end
        checks++; if (b_count !== 16'h0000) begin errors++; $display("FAIL reset_b_count got %h exp 0000", b_count); end
        checks++; if (b_sel !== 4'b0001 || b_seg !== 7'h3F || b_wrap !== 1'b0) begin errors++;
            $display("FAIL reset_b_disp got sel %b seg %h wrap %b exp 0001 3f 0", b_sel, b_seg, b_wrap); end
    endtask

    task automatic test_bcd();
        b_rst_n = 1; b_en = 1; b_up = 1;
        b_load = 1; b_lv = 16'h9999; cyc(); b_load = 0;
        checks++; if (b_count !== 16'h9999) begin errors++; $display("FAIL bcd_load got %h exp 9999", b_count); end
        repeat (3) cyc();
        checks++; if (b_count !== 16'h9999) begin errors++; $display("FAIL bcd_pre_tick got %h exp 9999", b_count); end
        cyc();
        checks++; if (b_count !== 16'h0000 || b_wrap !== 1'b1) begin errors++;
            $display("FAIL bcd_wrap_up got %h wrap %b exp 0000 1", b_count, b_wrap); end
        cyc();
        checks++; if (b_wrap !== 1'b0) begin errors++; $display("FAIL bcd_wrap_pulse got %b exp 0", b_wrap); end
        b_load = 1; b_lv = 16'h005A; cyc(); b_load = 0;
        checks++; if (b_count !== 16'h0050) begin errors++; $display("FAIL bcd_sanitize got %h exp 0050", b_count); end
        b_load = 1; b_lv = 16'h0010; cyc(); b_load = 0; b_up = 0;
        repeat (4) cyc();
        checks++; if (b_count !== 16'h0009 || b_wrap !== 1'b0) begin errors++;
            $display("FAIL bcd_borrow got %h wrap %b exp 0009 0", b_count, b_wrap); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [0:3] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        int idx;
        b_rst_n = 0; b_en = 0; cyc();
        b_rst_n = 1; b_load = 1; b_lv = 16'h1234; cyc(); b_load = 0;
        for (int e = 2; e < 12; e++) begin
            cyc();
            idx = ((e - 1) / 2) % 4;
            checks++;
            if (b_sel !== 4'(1 << idx) || b_seg !== exp_seg[idx]) begin errors++;
                $display("FAIL scan edge %0d got sel %b seg %h exp %b %h", e, b_sel, b_seg, 4'(1 << idx), exp_seg[idx]); end
        end
        b_rst_n = 0; cyc();
    endtask

    task automatic test_count_up();
        a_rst_n = 0; cyc();
        a_rst_n = 1; a_en = 1; a_up = 1; a_load = 0;
        for (int t = 1; t <= 18; t++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                checks++; if (a_count !== 8'(m_n) || a_wrap !== 1'b0) begin errors++;
                    $display("FAIL count_up got %h wrap %b exp %h 0", a_count, a_wrap, 8'(m_n)); end
            end
            checks++; if (a_count !== 8'(t)) begin errors++; $display("FAIL count_up_tick%0d got %h exp %h", t, a_count, 8'(t)); end
        end
    endtask

    task automatic test_wrap();
        a_en = 1; a_up = 1; a_load = 1; a_lv = 8'hFF; cyc(); a_load = 0;
        repeat (3) cyc();
        checks++; if (a_count !== 8'hFF || a_wrap !== 1'b0) begin errors++;
            $display("FAIL wrap_pre got %h wrap %b exp ff 0", a_count, a_wrap); end
        cyc();
        checks++; if (a_count !== 8'h00 || a_wrap !== 1'b1) begin errors++;
            $display("FAIL wrap_up got %h wrap %b exp 00 1", a_count, a_wrap); end
        cyc();
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_pulse got %b exp 0", a_wrap); end
        a_load = 1; a_lv = 8'h00; cyc(); a_load = 0; a_up = 0;
        repeat (4) cyc();
        checks++; if (a_count !== 8'hFF || a_wrap !== 1'b1) begin errors++;
            $display("FAIL wrap_dn got %h wrap %b exp ff 1", a_count, a_wrap); end
        cyc();
        checks++; if (a_wrap !== 1'b0) begin errors++; $display("FAIL wrap_dn_pulse got %b exp 0", a_wrap); end
    endtask

    task automatic test_enable_hold();
        a_up = 1; a_load = 1; a_lv = 8'h40; a_en = 1; cyc(); a_load = 0;
        cyc(); cyc();              // prescaler now part-way through its period
        a_en = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            checks++; if (a_count !== 8'h40 || a_wrap !== 1'b0) begin errors++;
                $display("FAIL en_hold got %h exp 40", a_count); end
        end
        a_en = 1; cyc();
        checks++; if (a_count !== 8'h40) begin errors++; $display("FAIL en_resume_early got %h exp 40", a_count); end
        cyc();
        checks++; if (a_count !== 8'h41) begin errors++; $display("FAIL en_resume_tick got %h exp 41", a_count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            a_rst_n = ($urandom_range(0, 149) != 0);
            a_en    = ($urandom_range(0, 3) != 0);
            a_up    = 1'($urandom_range(0, 1));
            a_load  = ($urandom_range(0, 24) == 0);
            a_lv    = 8'($urandom);
            if ($urandom_range(0, 9) == 0) a_lv = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            cyc();
            checks++; if (a_count !== 8'(m_n) || a_wrap !== m_wrap) begin errors++;
                $display("FAIL rand_count cyc %0d got %h wrap %b exp %h %b", c, a_count, a_wrap, 8'(m_n), m_wrap); end
            checks++; if (a_sel !== m_sel || (a_seg !== m_seg && a_seg !== m_seg2)) begin errors++;
                $display("FAIL rand_disp cyc %0d got sel %b seg %h exp %b %h", c, a_sel, a_seg, m_sel, m_seg); end
        end
        a_rst_n = 1;
    endtask

    task automatic test_reset_mid();
        a_rst_n = 1; a_en = 1; a_up = 1; a_load = 1; a_lv = 8'hE7; cyc(); a_load = 0;
        repeat (5) cyc();
        a_rst_n = 0; a_load = 1; a_lv = 8'hAB; cyc();
        a_rst_n = 1; a_load = 0; a_en = 0;
        checks++; if (a_count !== 8'h00 || a_wrap !== 1'b0) begin errors++;
            $display("FAIL reset_mid_count got %h wrap %b exp 00 0", a_count, a_wrap); end
        checks++; if (a_sel !== 2'b01 || a_seg !== 7'h3F) begin errors++;
            $display("FAIL reset_mid_disp got sel %b seg %h exp 01 3f", a_sel, a_seg); end
    endtask

    initial begin
        a_rst_n = 0; a_en = 0; a_up = 1; a_load = 0; a_lv = '0;
        b_rst_n = 0; b_en = 0; b_up = 1; b_load = 0; b_lv = '0;
        test_reset();
        test_bcd();
        test_scan();
        test_count_up();
        test_wrap();
        test_enable_hold();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
